// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and instruction word width.
package loader_pkg;

    localparam int RF_ADDR_BITS_DEFAULT = 3;

    // Instruction word = 4-bit opcode field plus two register-file addresses.
    function automatic int word_width(input int rf_bits);
        return 4 + 2 * rf_bits;
    endfunction

    localparam int WORD_W_DEFAULT = word_width(RF_ADDR_BITS_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV_LO = 3'd1,
        ST_RECV_HI = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Streams host bytes (low byte, then high byte) into instruction words and writes them
// into an external ROM, holding the CPU in reset until the whole program is loaded.
module program_loader
    import loader_pkg::*;
#(
    parameter int ROM_addressBits = 6,
    parameter int RF_addressBits  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ROM_addressBits:0]              prog_length,
    input  logic                                  in_valid,
    input  logic [7:0]                            in_data,
    output logic                                  in_ready,
    output logic                                  ROM_writeEnable,
    output logic [ROM_addressBits-1:0]            ROM_writeAddress,
    output logic [word_width(RF_addressBits)-1:0] ROM_writeData,
    output logic                                  cpu_rst_n,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output loader_state_e                         o_dbg_state
);

    localparam int W    = word_width(RF_addressBits);
    localparam int HI_W = W - 8;
    localparam logic [ROM_addressBits:0] MAX_LEN = {1'b1, {ROM_addressBits{1'b0}}};

    loader_state_e                r_state;
    loader_state_e                w_next;
    logic [ROM_addressBits:0]     r_length;
    logic [ROM_addressBits-1:0]   r_count;
    logic [7:0]                   r_lo;
    logic [ROM_addressBits-1:0]   r_wr_addr;
    logic [W-1:0]                 r_wr_data;

    logic w_can_start;
    logic w_start_ok;
    logic w_len_bad;
    logic w_last;

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
    // does not depend on in_valid, and the host holds in_data stable while waiting.
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_start_ok  = start && w_can_start;
    assign w_len_bad   = (prog_length == '0) || (prog_length > MAX_LEN);
    assign w_last      = ({1'b0, r_count} == (r_length - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_next = w_len_bad ? ST_ERROR : ST_RECV_LO;
                end
            end
            ST_RECV_LO: if (in_valid) w_next = ST_RECV_HI;
            ST_RECV_HI: if (in_valid) w_next = ST_WRITE;
            ST_WRITE:   w_next = w_last ? ST_DONE : ST_RECV_LO;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Address/data registers load on the high-byte transfer so they are valid during
    // the single WRITE cycle and then simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_length  <= '0;
            r_count   <= '0;
            r_lo      <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_start_ok && !w_len_bad) begin
                r_length <= prog_length;
                r_count  <= '0;
            end
            if ((r_state == ST_RECV_LO) && in_valid) begin
                r_lo <= in_data;
            end
            if ((r_state == ST_RECV_HI) && in_valid) begin
                r_wr_addr <= r_count;
                r_wr_data <= {in_data[HI_W-1:0], r_lo};
            end
            if ((r_state == ST_WRITE) && !w_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign in_ready         = (r_state == ST_RECV_LO) || (r_state == ST_RECV_HI);
    assign ROM_writeEnable  = (r_state == ST_WRITE);
    assign ROM_writeAddress = r_wr_addr;
    assign ROM_writeData    = r_wr_data;
    assign busy             = in_ready || (r_state == ST_WRITE);
    assign done             = (r_state == ST_DONE);
    assign cpu_rst_n        = (r_state == ST_DONE);
    assign error            = (r_state == ST_ERROR);
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: per-cycle comparison against a byte-count
// model of the loader plus literal checks of the directed load scenarios.
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW = 6;
    localparam int W  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   prog_length = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          ROM_writeEnable;
    logic [AW-1:0] ROM_writeAddress;
    logic [W-1:0]  ROM_writeData;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          error;
    loader_state_e dbg_state;

    program_loader #(.ROM_addressBits(AW), .RF_addressBits(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_length(prog_length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ROM_writeEnable(ROM_writeEnable), .ROM_writeAddress(ROM_writeAddress),
        .ROM_writeData(ROM_writeData), .cpu_rst_n(cpu_rst_n), .busy(busy),
        .done(done), .error(error), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 loading, 2 done, 3 error; progress is the
    // number of bytes accepted, and each completed pair costs one write cycle.
    int            m_mode;
    int            m_len;
    int            m_bytes;
    bit            m_wpend;
    logic [7:0]    m_lo;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_len = 0; m_bytes = 0; m_wpend = 0;
            m_lo = '0; m_addr = '0; m_data = '0;
        end else if (m_mode == 1) begin
            if (m_wpend) begin
                m_wpend = 0;
                if (m_bytes / 2 == m_len) m_mode = 2;
            end else if (in_valid) begin
                if (m_bytes % 2 == 0) begin
                    m_lo = in_data;
                end else begin
                    m_addr  = AW'(m_bytes / 2);
                    m_data  = {in_data[1:0], m_lo};
                    m_wpend = 1;
                end
                m_bytes++;
            end
        end else if (start) begin
            if (prog_length == 0 || int'(prog_length) > 64) begin
                m_mode = 3;
            end else begin
                m_mode  = 1;
                m_len   = int'(prog_length);
                m_bytes = 0;
            end
        end
    end

    logic [W-1:0]  rom [64];
    int            wr_count = 0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        checkv("in_ready", 32'(in_ready), 32'(m_mode == 1 && !m_wpend));
        checkv("we", 32'(ROM_writeEnable), 32'(m_mode == 1 && m_wpend));
        checkv("waddr", 32'(ROM_writeAddress), 32'(m_addr));
        checkv("wdata", 32'(ROM_writeData), 32'(m_data));
        checkv("busy", 32'(busy), 32'(m_mode == 1));
        checkv("done", 32'(done), 32'(m_mode == 2));
        checkv("cpu_rst_n", 32'(cpu_rst_n), 32'(m_mode == 2));
        checkv("error", 32'(error), 32'(m_mode == 3));
        if (ROM_writeEnable) begin
            rom[ROM_writeAddress] = ROM_writeData;
            wr_count++;
            last_addr = ROM_writeAddress;
        end
    end

    logic [7:0] bytes_q[$];

    function automatic logic [W-1:0] exp_word(input int i);
        logic [7:0] lo, hi;
        lo = bytes_q[2*i];
        hi = bytes_q[2*i+1];
        return {hi[1:0], lo};
    endfunction

    task automatic clear_log();
        wr_count = 0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
    endtask

    task automatic fill_random(input int n);
        bytes_q = {};
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start = 1'b1;
        prog_length = (AW+1)'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit gaps);
        int  i = 0;
        int  guard = 0;
        bit  prev_ready = 0;
        bit  prev_take = 0;
        while (i < n) begin
            @(negedge clk);
            if (prev_ready && !prev_take) checkv("in_ready_hold", 32'(in_ready), 32'd1);
            in_data  = bytes_q[i];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_ready = in_ready;
            prev_take  = in_valid && in_ready;
            if (prev_take) i++;
            guard++;
            if (guard > 5000) begin
                checkv("send_timeout", 32'(i), 32'(n));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_status();
        int k = 0;
        while (!(done || error) && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkv("status_timeout", 32'(done || error), 32'd1);
    endtask

    task automatic check_image(input string name, input int len);
        int bad = 0;
        for (int i = 0; i < len; i++) if (rom[i] !== exp_word(i)) bad++;
        checkv(name, 32'(bad), 32'd0);
    endtask

    task automatic run_load(input int len, input bit gaps);
        clear_log();
        do_start(len);
        send_bytes(2 * len, gaps);
        wait_status();
        checkv("load_done", 32'(done), 32'd1);
        checkv("load_writes", 32'(wr_count), 32'(len));
        check_image("load_image", len);
    endtask

    logic [W-1:0] img_a [4];
    int           wc;

    initial begin
        repeat (3) @(negedge clk);
        checkv("rst_in_ready", 32'(in_ready), 32'd0);
        checkv("rst_we", 32'(ROM_writeEnable), 32'd0);
        checkv("rst_addr", 32'(ROM_writeAddress), 32'd0);
        checkv("rst_data", 32'(ROM_writeData), 32'd0);
        checkv("rst_cpu", 32'(cpu_rst_n), 32'd0);
        checkv("rst_flags", 32'({busy, done, error}), 32'd0);
        rst_n = 1'b1;

        // Directed three-word load with known words.
        clear_log();
        bytes_q = '{8'h12, 8'h03, 8'h34, 8'h01, 8'hFF, 8'h02};
        do_start(3);
        send_bytes(6, 1'b0);
        wait_status();
        checkv("d_w0", 32'(rom[0]), 32'h312);
        checkv("d_w1", 32'(rom[1]), 32'h134);
        checkv("d_w2", 32'(rom[2]), 32'h2FF);
        checkv("d_count", 32'(wr_count), 32'd3);
        checkv("d_done", 32'(done), 32'd1);
        checkv("d_cpu", 32'(cpu_rst_n), 32'd1);

        // Zero length is rejected; a valid start clears the error.
        clear_log();
        do_start(0);
        checkv("z_error", 32'(error), 32'd1);
        checkv("z_cpu", 32'(cpu_rst_n), 32'd0);
        repeat (3) @(negedge clk);
        checkv("z_writes", 32'(wr_count), 32'd0);
        fill_random(2);
        do_start(1);
        checkv("z_clear", 32'(error), 32'd0);
        checkv("z_busy", 32'(busy), 32'd1);
        send_bytes(2, 1'b0);
        wait_status();
        checkv("z_done", 32'(done), 32'd1);
        check_image("z_image", 1);

        // Length bounds: 65 rejected, 64 fills the whole ROM.
        do_start(65);
        checkv("b_err65", 32'(error), 32'd1);
        fill_random(128);
        run_load(64, 1'b0);
        checkv("b_last", 32'(last_addr), 32'd63);

        // Restart from DONE.
        clear_log();
        fill_random(2);
        do_start(1);
        checkv("r_cpu_low", 32'(cpu_rst_n), 32'd0);
        checkv("r_done_low", 32'(done), 32'd0);
        send_bytes(2, 1'b0);
        wait_status();
        checkv("r_addr", 32'(last_addr), 32'd0);
        checkv("r_count", 32'(wr_count), 32'd1);
        checkv("r_done", 32'(done), 32'd1);
        check_image("r_image", 1);

        // Same four words with and without host gaps must give the same image.
        fill_random(8);
        run_load(4, 1'b0);
        for (int i = 0; i < 4; i++) img_a[i] = rom[i];
        run_load(4, 1'b1);
        wc = 0;
        for (int i = 0; i < 4; i++) if (rom[i] !== img_a[i]) wc++;
        checkv("g_same_image", 32'(wc), 32'd0);

        for (int it = 0; it < 6; it++) begin
            int len;
            len = $urandom_range(1, 8);
            fill_random(2 * len);
            run_load(len, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a load.
        clear_log();
        fill_random(4);
        do_start(2);
        send_bytes(3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkv("ar_in_ready", 32'(in_ready), 32'd0);
        checkv("ar_we", 32'(ROM_writeEnable), 32'd0);
        checkv("ar_addr", 32'(ROM_writeAddress), 32'd0);
        checkv("ar_data", 32'(ROM_writeData), 32'd0);
        checkv("ar_cpu", 32'(cpu_rst_n), 32'd0);
        checkv("ar_flags", 32'({busy, done, error}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wc = wr_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkv("ar_no_write", 32'(wr_count), 32'(wc));
        checkv("ar_idle", 32'({busy, done, error}), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
